game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_pkg.sv | 27 ++
 rtl/game_sequencer_beat_timer.sv | 62 ++++++
 rtl/game_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the piano-tiles game sequencer: state encodings,
// lane geometry and small decode helpers used by the top and its timer.
package game_sequencer_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_GAMEOVER  = 2'd3
    } game_state_e;

    // One-hot mask selecting a single lane.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        logic [NUM_LANES-1:0] one_v;
        one_v = {{(NUM_LANES-1){1'b0}}, 1'b1};
        return one_v << lane;
    endfunction

    // States in which the beat clock runs.
    function automatic logic is_active(input game_state_e st);
        return (st == ST_COUNTDOWN) || (st == ST_PLAY);
    endfunction

endpackage

// File: rtl/game_sequencer_beat_timer.sv
// Beat prescaler: counts 0..BEAT_DIV-1 while enabled and emits registered
// pulses aligned with count==0 (beat start) and count==BEAT_DIV/2 (mid-beat).
// The enable describes the *next* cycle, so the pulses land in the same
// cycle as the count value they decode. The count restarts from 0 on the
// first enabled cycle after an idle period.
module beat_timer #(
    parameter  int unsigned BEAT_DIV = 25_000_000,
    localparam int unsigned CNT_W    = $clog2(BEAT_DIV)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             en,
    input  logic             mid_en,
    output logic [CNT_W-1:0] count,
    output logic             beat_tick,
    output logic             mid_tick
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BEAT_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_COUNT = CNT_W'(BEAT_DIV / 2);
    localparam logic [CNT_W-1:0] ZERO_COUNT = {CNT_W{1'b0}};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             run_r;
    logic             tick_r;
    logic             mid_r;

    // Next count: advance and wrap only while running on consecutive cycles.
    always_comb begin
        count_s = ZERO_COUNT;
        if (en && run_r) begin
            if (count_r == LAST_COUNT) begin
                count_s = ZERO_COUNT;
            end else begin
                count_s = count_r + CNT_W'(1);
            end
        end else begin
            count_s = ZERO_COUNT;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_r <= ZERO_COUNT;
            run_r   <= 1'b0;
            tick_r  <= 1'b0;
            mid_r   <= 1'b0;
        end else begin
            count_r <= count_s;
            run_r   <= en;
            tick_r  <= en && (count_s == ZERO_COUNT);
            mid_r   <= en && mid_en && (count_s == HALF_COUNT);
        end
    end

    assign count     = count_r;
    assign beat_tick = tick_r;
    assign mid_tick  = mid_r;

endmodule

// File: rtl/game_sequencer.sv
// Rhythm-game sequencer: IDLE -> COUNTDOWN -> PLAY -> GAMEOVER. Key presses
// are latched during the first half of each beat and judged at mid-beat;
// all pulse and status outputs come straight from flops.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned BEAT_DIV        = 25_000_000,
    parameter int unsigned COUNTDOWN_BEATS = 3,
    parameter int unsigned MAX_MISSES      = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start_pulse,
    input  logic [NUM_LANES-1:0] lane_keys,
    input  logic                 tile_valid,
    input  logic [LANE_W-1:0]    tile_lane,
    output logic                 beat_tick,
    output logic                 judge_strobe,
    output logic                 score_inc,
    output logic                 miss,
    output logic                 clear_score,
    output logic [1:0]           misses,
    output logic                 running,
    output logic                 game_over,
    output logic [1:0]           state
);

    localparam int unsigned      CNT_W          = $clog2(BEAT_DIV);
    localparam logic [CNT_W-1:0] LAST_COUNT     = CNT_W'(BEAT_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_COUNT     = CNT_W'(BEAT_DIV / 2);
    localparam logic [CNT_W-1:0] PRE_JUDGE      = CNT_W'(BEAT_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] ZERO_COUNT     = {CNT_W{1'b0}};
    localparam logic [3:0]       CD_LAST        = 4'(COUNTDOWN_BEATS - 1);
    localparam logic [1:0]       MISS_LIMIT     = 2'(MAX_MISSES);

    game_state_e          state_r;
    game_state_e          state_s;
    logic [CNT_W-1:0]     beat_count_s;
    logic                 beat_tick_s;
    logic                 judge_strobe_s;
    logic                 timer_en_s;
    logic                 judge_en_s;
    logic                 beat_end_s;
    logic                 entering_cd_s;

    logic [NUM_LANES-1:0] prev_keys_r;
    logic [NUM_LANES-1:0] key_rise_s;
    logic [NUM_LANES-1:0] target_mask_s;
    logic                 window_open_s;
    logic                 hit_r;
    logic                 wrong_r;
    logic                 hit_s;
    logic                 wrong_s;

    logic [3:0]           cd_beats_r;
    logic [3:0]           cd_beats_s;
    logic [1:0]           misses_r;
    logic [1:0]           misses_s;
    logic                 pre_judge_s;
    logic                 score_r;
    logic                 score_s;
    logic                 miss_r;
    logic                 miss_s;
    logic                 clear_r;
    logic                 clear_s;
    logic                 running_r;
    logic                 game_over_r;

    assign timer_en_s = is_active(state_s);
    assign judge_en_s = (state_s == ST_PLAY);
    assign beat_end_s = (beat_count_s == LAST_COUNT);

    beat_timer #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_timer (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .en        (timer_en_s),
        .mid_en    (judge_en_s),
        .count     (beat_count_s),
        .beat_tick (beat_tick_s),
        .mid_tick  (judge_strobe_s)
    );

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: countdown hands over to PLAY exactly at a beat boundary.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_pulse) state_s = ST_COUNTDOWN;
                else             state_s = ST_IDLE;
            end
            ST_COUNTDOWN: begin
                if (beat_end_s && (cd_beats_r == CD_LAST)) state_s = ST_PLAY;
                else                                       state_s = ST_COUNTDOWN;
            end
            ST_PLAY: begin
                if (misses_r >= MISS_LIMIT) state_s = ST_GAMEOVER;
                else                        state_s = ST_PLAY;
            end
            ST_GAMEOVER: begin
                if (start_pulse) state_s = ST_COUNTDOWN;
                else             state_s = ST_GAMEOVER;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Per-beat press latches: cleared at beat start, fed only before judgement.
    always_comb begin
        key_rise_s    = lane_keys & ~prev_keys_r;
        target_mask_s = lane_onehot(tile_lane);
        window_open_s = (state_r == ST_PLAY) && (beat_count_s < HALF_COUNT);
        if ((state_r != ST_PLAY) || (beat_count_s == ZERO_COUNT)) begin
            hit_s   = 1'b0;
            wrong_s = 1'b0;
        end else begin
            hit_s   = hit_r;
            wrong_s = wrong_r;
        end
        hit_s   = hit_s   | (window_open_s && |(key_rise_s & target_mask_s));
        wrong_s = wrong_s | (window_open_s && |(key_rise_s & ~target_mask_s));
    end

    // FSM outputs: next values of the registered pulses and counters. The
    // verdict is formed one cycle before mid-beat so it lands with the strobe.
    always_comb begin
        entering_cd_s = (state_s == ST_COUNTDOWN) && (state_r != ST_COUNTDOWN);
        pre_judge_s   = (state_r == ST_PLAY) && (state_s == ST_PLAY) &&
                        (beat_count_s == PRE_JUDGE);
        score_s       = 1'b0;
        miss_s        = 1'b0;
        if (pre_judge_s) begin
            if (tile_valid) begin
                if (hit_s && !wrong_s) score_s = 1'b1;
                else                   miss_s  = 1'b1;
            end else begin
                if (wrong_s) miss_s = 1'b1;
                else         miss_s = 1'b0;
            end
        end else begin
            score_s = 1'b0;
            miss_s  = 1'b0;
        end

        clear_s = entering_cd_s;

        if (entering_cd_s) begin
            misses_s = 2'd0;
        end else if (miss_s && (misses_r < MISS_LIMIT)) begin
            misses_s = misses_r + 2'd1;
        end else begin
            misses_s = misses_r;
        end

        if (entering_cd_s) begin
            cd_beats_s = 4'd0;
        end else if ((state_r == ST_COUNTDOWN) && beat_end_s) begin
            cd_beats_s = cd_beats_r + 4'd1;
        end else begin
            cd_beats_s = cd_beats_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prev_keys_r <= {NUM_LANES{1'b0}};
            hit_r       <= 1'b0;
            wrong_r     <= 1'b0;
            cd_beats_r  <= 4'd0;
            misses_r    <= 2'd0;
            score_r     <= 1'b0;
            miss_r      <= 1'b0;
            clear_r     <= 1'b0;
            running_r   <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            prev_keys_r <= lane_keys;
            hit_r       <= hit_s;
            wrong_r     <= wrong_s;
            cd_beats_r  <= cd_beats_s;
            misses_r    <= misses_s;
            score_r     <= score_s;
            miss_r      <= miss_s;
            clear_r     <= clear_s;
            running_r   <= (state_s == ST_PLAY);
            game_over_r <= (state_s == ST_GAMEOVER);
        end
    end

    assign beat_tick    = beat_tick_s;
    assign judge_strobe = judge_strobe_s;
    assign score_inc    = score_r;
    assign miss         = miss_r;
    assign clear_score  = clear_r;
    assign misses       = misses_r;
    assign running      = running_r;
    assign game_over    = game_over_r;
    assign state        = state_r;

endmodule
